event_blinker: RTL and testbench
================================

# event_blinker

Output-side companion to the button input chain. It converts single-cycle event strobes, such as the edge outputs of the debounced button path, into human-visible LED blinks of fixed on/off duration. Events that arrive during a blink are optionally queued and replayed, one blink per event. It sits between event-producing logic and a board LED pin.

## Interface
Parameters:
- ON_TICKS, default 5_000_000: clk cycles the LED is held high per blink; must be ≥1.
- OFF_TICKS, default 5_000_000: clk cycles the LED is held low after each blink; must be ≥1.
- MAX_PENDING, default 7: queued-event capacity, used only with BLINK_QUEUE_EN; must be ≥1.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high reset.
- trigger, input, 1: event strobe; each high cycle is one event.
- led, output, 1: registered blink output.
- busy, output, 1: high whenever the state is not IDLE.
- dropped, output, 1: one-cycle pulse when an event is discarded.
- pending, output, $clog2(MAX_PENDING+1): queued event count; driven 0 without BLINK_QUEUE_EN.

## Operation
- States are IDLE, ON and OFF.
- A single down-counter `phase_cnt` times each phase. Its width is $clog2(max(ON_TICKS,OFF_TICKS)).
- IDLE, trigger=1: go to ON and load phase_cnt=ON_TICKS-1.
- ON, phase_cnt==0: go to OFF and load OFF_TICKS-1. Otherwise decrement.
- OFF, phase_cnt==0:
  - pending>0: go to ON, load ON_TICKS-1, and decrement pending.
  - pending==0: go to IDLE.
- OFF, phase_cnt!=0: decrement.
- trigger in ON or OFF with BLINK_QUEUE_EN:
  - pending<MAX_PENDING: increment pending.
  - pending==MAX_PENDING: pending holds and dropped pulses.
- Simultaneous trigger and dequeue (the last OFF cycle with pending>0): pending is unchanged, and the event is never dropped.
- Trigger on the last OFF cycle with pending==0: the event is queued, giving pending=1 in IDLE. It is consumed on the next cycle, moving IDLE to ON with the decrement.
  - Consequently, IDLE also starts a blink when pending>0.
- trigger in IDLE always starts a blink and never queues or drops.
- All counters saturate or are loaded explicitly. No wrap-around is permitted.

## Timing
Reset values: led=0, busy=0, dropped=0, pending=0, state=IDLE, phase_cnt=0. Reset overrides all activity, including mid-blink; led falls on the cycle after reset is sampled.

Latency and durations:
- trigger sampled at edge t in IDLE: led=1 and busy=1 from t+1.
- led is high for exactly ON_TICKS cycles, then low for exactly OFF_TICKS cycles while busy stays high.
- busy falls at t+1+ON_TICKS+OFF_TICKS if no event is queued.
- Back-to-back queued blinks have no gap beyond OFF_TICKS.
- dropped asserts in the cycle after the offending trigger is sampled, for one cycle.

## Configuration
Macro: BLINK_QUEUE_EN.
- Defined: the pending counter, the queueing behaviour and the pending port logic are present.
- Undefined:
  - Every trigger while busy is ignored and pulses dropped.
  - pending is tied to 0.
  - The pending-driven restart paths from OFF and IDLE are removed.

## Structure
- Package `button_pkg`:
  - `blink_state_t` enum (IDLE, ON, OFF).
  - A shared `max_u` helper for the counter width.
- Sub-module `phase_timer`:
  - Loadable down-counter with load, load_value and zero outputs.
  - Instantiated once by event_blinker.

## Test plan
All scenarios use ON_TICKS=4, OFF_TICKS=3 and MAX_PENDING=2.
1. Single trigger at cycle 10 -> led high on cycles 11–14, low on 15–17, busy cycles 11–17, pending stays 0.
2. With BLINK_QUEUE_EN, triggers at cycles 10, 12 and 13 -> pending reaches 2, followed by three contiguous blinks.
   - led high on cycles 11–14, 18–21 and 25–28.
   - busy falls after cycle 31.
3. With BLINK_QUEUE_EN, five triggers on cycles 10–14 -> pending saturates at 2, dropped pulses on cycles 14 and 15, and exactly three blinks occur.
4. Trigger on the last OFF cycle (17) after a blink started at 10 -> the second blink starts with led=1 from cycle 19; without the macro, dropped pulses at 18 and led stays 0.
5. Reset asserted at cycle 13 mid-blink with pending=1 -> from cycle 14 led=0, busy=0 and pending=0, and no further blink occurs.
6. Without BLINK_QUEUE_EN, trigger held high for cycles 10–20 -> one blink starting at 11, dropped pulses for cycles 12–18, and a second blink starts at 19 when trigger is seen in IDLE.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared blinker state encoding and width helper
package button_pkg;
   typedef enum logic [1:0] {IDLE, ON, OFF} blink_state_t;
   function automatic int max_u(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable saturating down-counter with zero flag
module phase_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_value : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
   always_ff @(posedge clk)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   assign zero = cnt_q == '0;
endmodule

// File: rtl/event_blinker.sv
// event_blinker: turns event strobes into fixed-length LED blinks; BLINK_QUEUE_EN adds an event queue
module event_blinker
   import button_pkg::*;
#(
   parameter int ON_TICKS    = 5_000_000,
   parameter int OFF_TICKS   = 5_000_000,
   parameter int MAX_PENDING = 7
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 trigger,
   output logic                                 led,
   output logic                                 busy,
   output logic                                 dropped,
   output logic [$clog2(MAX_PENDING+1)-1:0]     pending
);
   localparam int CW = max_u($clog2(max_u(ON_TICKS, OFF_TICKS)), 1);
   localparam int PW = $clog2(MAX_PENDING + 1);
   localparam logic [CW-1:0] ON_V  = CW'(ON_TICKS - 1);
   localparam logic [CW-1:0] OFF_V = CW'(OFF_TICKS - 1);

   blink_state_t  state_q, state_d;
   logic          led_q, led_d, busy_q, busy_d, dropped_q, dropped_d;
   logic [PW-1:0] pend_q, pend_d;
   logic          idle, has_pend, start_idle, on_done, off_done, restart, load, zero;
   logic [CW-1:0] load_value;

   phase_timer #(.W(CW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .zero       (zero)
   );

   always_comb begin
      idle       = state_q == IDLE;
`ifdef BLINK_QUEUE_EN
      has_pend   = pend_q != '0;
`else
      has_pend   = 1'b0;
`endif
      start_idle = idle && (trigger || has_pend);
      on_done    = state_q == ON && zero;
      off_done   = state_q == OFF && zero;
      restart    = off_done && has_pend;
      state_d    = (start_idle || restart) ? ON : on_done ? OFF : off_done ? IDLE : state_q;
      load       = start_idle || restart || on_done;
      load_value = on_done ? OFF_V : ON_V;
      led_d      = state_d == ON;
      busy_d     = state_d != IDLE;
   end

`ifdef BLINK_QUEUE_EN
   logic enq, deq, full;
   // an IDLE trigger starts the blink itself, so any queued event stays queued
   always_comb begin
      enq       = trigger && !idle;
      deq       = restart || (idle && !trigger && has_pend);
      full      = pend_q == PW'(MAX_PENDING);
      pend_d    = (enq && deq) ? pend_q : (enq && !full) ? pend_q + 1'b1 : deq ? pend_q - 1'b1 : pend_q;
      dropped_d = enq && full && !deq;
   end
`else
   always_comb begin
      pend_d    = '0;
      dropped_d = trigger && !idle;
   end
`endif

   always_ff @(posedge clk)
      if (reset) begin
         state_q   <= IDLE;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         busy_q    <= busy_d;
         dropped_q <= dropped_d;
         pend_q    <= pend_d;
      end

   assign led     = led_q;
   assign busy    = busy_q;
   assign dropped = dropped_q;
   assign pending = pend_q;
endmodule

// File: tb/tb_event_blinker.sv
// tb_event_blinker: directed cycle-mask checks for event_blinker (ON=4, OFF=3, MAX_PENDING=2)
module tb_event_blinker;
   logic       clk = 1'b0, reset = 1'b1, trigger = 1'b0;
   logic       led, busy, dropped;
   logic [1:0] pending;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   event_blinker #(.ON_TICKS(4), .OFF_TICKS(3), .MAX_PENDING(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .trigger (trigger),
      .led     (led),
      .busy    (busy),
      .dropped (dropped),
      .pending (pending)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] bit_at(input int b);
      return rng(b, b);
   endfunction

   // bit c of each mask is the value seen during cycle c; cycle c inputs are sampled at edge c
   task automatic run(input string tag, input logic [63:0] trig, input logic [63:0] rstm,
                      input logic [63:0] el, input logic [63:0] eb, input logic [63:0] ed,
                      input int pc, input logic [1:0] ep);
      logic [63:0] lt = '0, bt = '0, dt = '0;
      logic [1:0]  pt = '0;
      reset = 1'b1;
      trigger = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check({tag, "/rst"}, {59'd0, led, busy, dropped, pending}, 64'd0);
      for (int c = 0; c < 40; c++) begin
         trigger = trig[c];
         reset = rstm[c];
         @(posedge clk);
         #1;
         lt[c+1] = led;
         bt[c+1] = busy;
         dt[c+1] = dropped;
         if (c + 1 == pc) pt = pending;
      end
      reset = 1'b0;
      trigger = 1'b0;
      check({tag, "/led"}, lt, el);
      check({tag, "/busy"}, bt, eb);
      check({tag, "/dropped"}, dt, ed);
      check({tag, "/pending"}, {62'd0, pt}, {62'd0, ep});
   endtask

   initial begin
      run("single", bit_at(10), '0, rng(11, 14), rng(11, 17), '0, 14, 2'd0);
`ifdef BLINK_QUEUE_EN
      run("queue3", bit_at(10) | rng(12, 13), '0,
          rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31), '0, 14, 2'd2);
      run("saturate", rng(10, 14), '0,
          rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31), rng(14, 15), 14, 2'd2);
      run("lastoff", bit_at(10) | bit_at(17), '0,
          rng(11, 14) | rng(19, 22), rng(11, 17) | rng(19, 25), '0, 18, 2'd1);
      run("midreset", rng(10, 11), bit_at(13), rng(11, 13), rng(11, 13), '0, 12, 2'd1);
      run("held", rng(10, 20), '0,
          rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35), rng(11, 38),
          rng(14, 17) | rng(19, 21), 22, 2'd2);
`else
      run("queue3", bit_at(10) | rng(12, 13), '0, rng(11, 14), rng(11, 17), rng(13, 14), 14, 2'd0);
      run("saturate", rng(10, 14), '0, rng(11, 14), rng(11, 17), rng(12, 15), 14, 2'd0);
      run("lastoff", bit_at(10) | bit_at(17), '0, rng(11, 14), rng(11, 17), bit_at(18), 18, 2'd0);
      run("midreset", rng(10, 11), bit_at(13), rng(11, 13), rng(11, 13), bit_at(12), 12, 2'd0);
      run("held", rng(10, 20), '0, rng(11, 14) | rng(19, 22), rng(11, 17) | rng(19, 25),
          rng(12, 18) | rng(20, 21), 22, 2'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
